mem_access_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_access_stage_if.sv | 36 +++
 rtl/mem_lane_align.sv | 27 ++
 rtl/mem_access_stage.sv | 109 ++++++++++
 tb/tb_mem_access_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, FSM state type and op legality helper for the MEM stage
package mem_pkg;
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic {IDLE, RMW_WR} state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: upstream, data-memory and MEM/WB signals; o_range_err exists only with MEM_RANGE_CHECK_EN
interface mem_access_stage_if #(
    parameter int ADDR_BITS = 6
);
    logic                 i_valid, o_ready, i_mem_en, i_reg_write;
    logic [3:0]           i_op;
    logic [31:0]          i_alu_result, i_store_data;
    logic [4:0]           i_rd;
    logic [ADDR_BITS-1:0] o_mem_addr;
    logic                 o_mem_wr_en;
    logic [31:0]          o_mem_wdata, i_mem_rdata;
    logic                 o_wb_valid, o_wb_reg_write, o_misaligned;
    logic [31:0]          o_wb_data;
    logic [4:0]           o_wb_rd;
`ifdef MEM_RANGE_CHECK_EN
    logic                 o_range_err;
`endif

    modport slave (
        input  i_valid, i_mem_en, i_op, i_alu_result, i_store_data, i_rd, i_reg_write, i_mem_rdata,
`ifdef MEM_RANGE_CHECK_EN
        output o_range_err,
`endif
        output o_ready, o_mem_addr, o_mem_wr_en, o_mem_wdata,
        output o_wb_valid, o_wb_data, o_wb_rd, o_wb_reg_write, o_misaligned
    );

    modport master (
        output i_valid, i_mem_en, i_op, i_alu_result, i_store_data, i_rd, i_reg_write, i_mem_rdata,
`ifdef MEM_RANGE_CHECK_EN
        input  o_range_err,
`endif
        input  o_ready, o_mem_addr, o_mem_wr_en, o_mem_wdata,
        input  o_wb_valid, o_wb_data, o_wb_rd, o_wb_reg_write, o_misaligned
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian lane extract with sign/zero extension, RMW lane merge, alignment check
module mem_lane_align (
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] data,
    output logic [31:0] ld_val,
    output logic [31:0] merged,
    output logic        misaligned
);
    logic [4:0]  bsh, hsh;
    logic [31:0] bword, hword;

    assign bsh   = {~off, 3'b000};
    assign hsh   = {~off[1], 4'b0000};
    assign bword = word >> bsh;
    assign hword = word >> hsh;

    // byte k sits at bit 8*(3-k); op[2] selects zero extension, op[0] selects halfword
    always_comb begin
        ld_val = op[1:0] == 2'b00 ? {{24{~op[2] & bword[7]}}, bword[7:0]} :
                 op[1:0] == 2'b01 ? {{16{~op[2] & hword[15]}}, hword[15:0]} : word;
        merged = op[0] ? (word & ~(32'hFFFF << hsh)) | ({16'b0, data} << hsh)
                       : (word & ~(32'hFF << bsh)) | ({24'b0, data[7:0]} << bsh);
        misaligned = op[1] ? |off : op[0] & off[0];
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with sub-word RMW stores and MEM/WB register; optional MEM_RANGE_CHECK_EN
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input logic clk,
    input logic rst,
    mem_access_stage_if.slave bus
);
    state_t               state, state_nxt;
    logic                 rmw, accept, legal, rerr, mis, ok, rmw_go, sw_go;
    logic [2:0]           cap_op, al_op;
    logic [ADDR_BITS-1:0] cap_addr, al_addr;
    logic [31:0]          cap_word, al_word, ld_val, merged;
    logic [15:0]          cap_data, al_data;
    logic [4:0]           cap_rd;

    assign rmw    = state == RMW_WR;
    assign accept = bus.i_valid & ~rmw;
    assign legal  = is_legal(bus.i_op);
`ifdef MEM_RANGE_CHECK_EN
    assign rerr   = |bus.i_alu_result[31:ADDR_BITS];
`else
    assign rerr   = 1'b0;
`endif
    assign ok     = bus.i_mem_en & legal & ~mis & ~rerr;
    assign rmw_go = accept & ok & bus.i_op[3] & (bus.i_op[1:0] != 2'b11);
    assign sw_go  = accept & ok & (bus.i_op == OP_SW);

    assign al_op   = rmw ? cap_op : bus.i_op[2:0];
    assign al_addr = rmw ? cap_addr : bus.i_alu_result[ADDR_BITS-1:0];
    assign al_word = rmw ? cap_word : bus.i_mem_rdata;
    assign al_data = rmw ? cap_data : bus.i_store_data[15:0];

    mem_lane_align u_align (
        .op        (al_op),
        .off       (al_addr[1:0]),
        .word      (al_word),
        .data      (al_data),
        .ld_val    (ld_val),
        .merged    (merged),
        .misaligned(mis)
    );

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    // next state and memory-side outputs; RMW_WR writes the merged word unless reset cuts it
    always_comb begin
        state_nxt       = rmw_go ? RMW_WR : IDLE;
        bus.o_ready     = ~rmw;
        bus.o_mem_wr_en = ~rst & (rmw | sw_go);
        bus.o_mem_wdata = rmw ? merged : bus.i_store_data;
        bus.o_mem_addr  = {al_addr[ADDR_BITS-1:2], 2'b00};
    end

    // capture the old word and store operands for the RMW write cycle
    always_ff @(posedge clk)
        if (rst) begin
            cap_op   <= '0;
            cap_addr <= '0;
            cap_word <= '0;
            cap_data <= '0;
            cap_rd   <= '0;
        end else if (rmw_go) begin
            cap_op   <= bus.i_op[2:0];
            cap_addr <= bus.i_alu_result[ADDR_BITS-1:0];
            cap_word <= bus.i_mem_rdata;
            cap_data <= bus.i_store_data[15:0];
            cap_rd   <= bus.i_rd;
        end

    // MEM/WB register; fault flags are single-cycle pulses alongside o_wb_valid
    always_ff @(posedge clk)
        if (rst) begin
            bus.o_wb_valid     <= 1'b0;
            bus.o_wb_data      <= '0;
            bus.o_wb_rd        <= '0;
            bus.o_wb_reg_write <= 1'b0;
            bus.o_misaligned   <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            bus.o_range_err    <= 1'b0;
`endif
        end else if (rmw) begin
            bus.o_wb_valid     <= 1'b1;
            bus.o_wb_rd        <= cap_rd;
            bus.o_wb_reg_write <= 1'b0;
            bus.o_misaligned   <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            bus.o_range_err    <= 1'b0;
`endif
        end else if (accept) begin
            bus.o_wb_valid     <= ~rmw_go;
            bus.o_wb_data      <= bus.i_mem_en ? ld_val : bus.i_alu_result;
            bus.o_wb_rd        <= bus.i_rd;
            bus.o_wb_reg_write <= bus.i_reg_write & (~bus.i_mem_en | (ok & ~bus.i_op[3]));
            bus.o_misaligned   <= bus.i_mem_en & legal & mis;
`ifdef MEM_RANGE_CHECK_EN
            bus.o_range_err    <= bus.i_mem_en & legal & rerr;
`endif
        end else begin
            bus.o_wb_valid     <= 1'b0;
            bus.o_misaligned   <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            bus.o_range_err    <= 1'b0;
`endif
        end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus reset-during-RMW and pulse-width sequences
module tb_mem_access_stage;
    import mem_pkg::*;

    typedef struct {
        logic        mem_en;
        logic [3:0]  op;
        logic [31:0] addr, sdata, exp_data;
        logic        chk_data, exp_regw, exp_mis;
        int          exp_stall, exp_writes;
        logic [5:0]  chk_word;
        logic [31:0] exp_word;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, init_mem = 1'b1;
    logic [31:0] mem [16];
    int          checks = 0, errors = 0, writes = 0;
    vec_t        v [$];

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_BITS(6)) bus ();
    mem_access_stage #(.ADDR_BITS(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.i_mem_rdata = mem[bus.o_mem_addr[5:2]];

    always @(posedge clk)
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h80FF7F01;
        end else if (bus.o_mem_wr_en) begin
            mem[bus.o_mem_addr[5:2]] <= bus.o_mem_wdata;
            writes++;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic en, logic [3:0] op, logic [31:0] a, logic [31:0] d, logic [31:0] ed,
                                logic cd, logic rw, logic mi, int st, int wr, logic [5:0] cw, logic [31:0] ew);
        vec_t t;
        t.mem_en = en; t.op = op; t.addr = a; t.sdata = d; t.exp_data = ed; t.chk_data = cd;
        t.exp_regw = rw; t.exp_mis = mi; t.exp_stall = st; t.exp_writes = wr; t.chk_word = cw; t.exp_word = ew;
        return t;
    endfunction

    task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        bus.i_mem_en = en; bus.i_op = op; bus.i_alu_result = a; bus.i_store_data = d;
        bus.i_rd = rd; bus.i_reg_write = 1'b1; bus.i_valid = 1'b1;
    endtask

    task automatic issue(input vec_t t, input logic [4:0] rd, output int stall);
        drive(t.mem_en, t.op, t.addr, t.sdata, rd);
        @(posedge clk); #1;
        stall = 0;
        while (!bus.o_ready && stall < 4) begin
            stall++;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int st, w0;
        v.push_back(mk(1, OP_LB,  32'h08, 32'h0,        32'hFFFFFF80, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LBU, 32'h08, 32'h0,        32'h00000080, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LH,  32'h0A, 32'h0,        32'h00007F01, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LHU, 32'h08, 32'h0,        32'h000080FF, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LB,  32'h0B, 32'h0,        32'h00000001, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LBU, 32'h0A, 32'h0,        32'h0000007F, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_LB,  32'h09, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 0, 0, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_SB,  32'h09, 32'hFFFFFF55, 32'h0,        0, 0, 0, 1, 1, 6'h08, 32'h80557F01));
        v.push_back(mk(1, OP_LW,  32'h08, 32'h0,        32'h80557F01, 1, 1, 0, 0, 0, 6'h08, 32'h80557F01));
        v.push_back(mk(1, OP_SW,  32'h08, 32'h80FF7F01, 32'h0,        0, 0, 0, 0, 1, 6'h08, 32'h80FF7F01));
        v.push_back(mk(1, OP_SH,  32'h0A, 32'h0000ABCD, 32'h0,        0, 0, 0, 1, 1, 6'h08, 32'h80FFABCD));
        v.push_back(mk(1, OP_SW,  32'h0C, 32'h12345678, 32'h0,        0, 0, 0, 0, 1, 6'h0C, 32'h12345678));
        v.push_back(mk(1, OP_LW,  32'h06, 32'h0,        32'h0,        0, 0, 1, 0, 0, 6'h04, 32'h00000000));
        v.push_back(mk(1, OP_SH,  32'h09, 32'h00001234, 32'h0,        0, 0, 1, 0, 0, 6'h08, 32'h80FFABCD));
        v.push_back(mk(1, OP_SB,  32'h0F, 32'h000000AA, 32'h0,        0, 0, 0, 1, 1, 6'h0C, 32'h123456AA));
        v.push_back(mk(1, OP_SH,  32'h0C, 32'hFFFF1111, 32'h0,        0, 0, 0, 1, 1, 6'h0C, 32'h111156AA));
        v.push_back(mk(0, OP_SW,  32'hDEADBEEF, 32'h0,  32'hDEADBEEF, 1, 1, 0, 0, 0, 6'h08, 32'h80FFABCD));
        v.push_back(mk(1, 4'b0010, 32'h08, 32'h0,       32'h0,        0, 0, 0, 0, 0, 6'h08, 32'h80FFABCD));
`ifdef MEM_RANGE_CHECK_EN
        v.push_back(mk(1, OP_LW,  32'h148, 32'h0,       32'h0,        0, 0, 0, 0, 0, 6'h08, 32'h80FFABCD));
`else
        v.push_back(mk(1, OP_LW,  32'h148, 32'h0,       32'h80FFABCD, 1, 1, 0, 0, 0, 6'h08, 32'h80FFABCD));
`endif
        v.push_back(mk(1, OP_LBU, 32'h0D, 32'h0,        32'h00000011, 1, 1, 0, 0, 0, 6'h0C, 32'h111156AA));

        drive(0, 4'h0, 32'h0, 32'h0, 5'd0);
        bus.i_valid = 1'b0; bus.i_reg_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; init_mem = 1'b0;
        #1;
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_wb_valid", bus.o_wb_valid, 0);
        chk("rst_wb_data", bus.o_wb_data, 0);
        chk("rst_wb_rd", bus.o_wb_rd, 0);
        chk("rst_wb_regw", bus.o_wb_reg_write, 0);
        chk("rst_mis", bus.o_misaligned, 0);
        chk("rst_wr_en", bus.o_mem_wr_en, 0);

        for (int i = 0; i < v.size(); i++) begin
            w0 = writes;
            issue(v[i], 5'(i + 1), st);
            chk($sformatf("v%0d_valid", i), bus.o_wb_valid, 1);
            chk($sformatf("v%0d_rd", i), bus.o_wb_rd, 32'(i + 1));
            chk($sformatf("v%0d_regw", i), bus.o_wb_reg_write, v[i].exp_regw);
            chk($sformatf("v%0d_mis", i), bus.o_misaligned, v[i].exp_mis);
            chk($sformatf("v%0d_stall", i), st, v[i].exp_stall);
            chk($sformatf("v%0d_writes", i), writes - w0, v[i].exp_writes);
            chk($sformatf("v%0d_mem", i), mem[v[i].chk_word[5:2]], v[i].exp_word);
            if (v[i].chk_data) chk($sformatf("v%0d_data", i), bus.o_wb_data, v[i].exp_data);
        end

        @(posedge clk); #1;
        chk("idle_valid", bus.o_wb_valid, 0);
        chk("idle_data_hold", bus.o_wb_data, 32'h00000011);

        issue(mk(1, OP_LHU, 32'h03, 32'h0, 32'h0, 0, 0, 1, 0, 0, 6'h0, 32'h0), 5'd3, st);
        chk("mis_pulse", bus.o_misaligned, 1);
        @(posedge clk); #1;
        chk("mis_drop", bus.o_misaligned, 0);

        drive(1, OP_SB, 32'h0C, 32'h00000077, 5'd9);
        @(posedge clk); #1;
        chk("rmw_stall", bus.o_ready, 0);
        w0 = writes;
        rst = 1'b1;
        #1 chk("rst_rmw_wr_en", bus.o_mem_wr_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 4'h0, 32'h0, 32'h0, 5'd0);
        bus.i_valid = 1'b0; bus.i_reg_write = 1'b0;
        #1;
        chk("rst_rmw_writes", writes - w0, 0);
        chk("rst_rmw_mem", mem[3], 32'h111156AA);
        chk("rst_rmw_ready", bus.o_ready, 1);
        chk("rst_rmw_valid", bus.o_wb_valid, 0);
        chk("rst_rmw_data", bus.o_wb_data, 0);
        chk("rst_rmw_rd", bus.o_wb_rd, 0);
        issue(mk(1, OP_LW, 32'h0C, 32'h0, 32'h0, 0, 0, 0, 0, 0, 6'h0, 32'h0), 5'd4, st);
        chk("post_rst_lw", bus.o_wb_data, 32'h111156AA);

`ifdef MEM_RANGE_CHECK_EN
        w0 = writes;
        issue(mk(1, OP_SW, 32'h100, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0, 0, 6'h0, 32'h0), 5'd5, st);
        chk("range_err_sw", bus.o_range_err, 1);
        chk("range_writes", writes - w0, 0);
        issue(mk(1, OP_LW, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0, 0, 6'h0, 32'h0), 5'd6, st);
        chk("range_err_lw", bus.o_range_err, 1);
        chk("range_regw", bus.o_wb_reg_write, 0);
        @(posedge clk); #1;
        chk("range_drop", bus.o_range_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
